serial_load_arbiter: RTL and testbench
======================================

# serial_load_arbiter

Paces and arbitrates bytes into the emulated ACIA receive path of the UK101 core. It takes two sources: a file-download byte stream from the HPS (BASIC/monitor text injection) and live bytes from the UART deserializer, and merges them into a single valid/ready stream. Download bytes pass through a FIFO and are rate-limited to the selected baud character time. An optional extra delay follows each carriage return so BASIC can finish tokenising a line. The block sits between `hps_io`/UART RX and the `uk101` ACIA receive-injection port, clocked on the core system clock.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `FIFO_DEPTH`, 16, download FIFO entries; power of two, ≥2.
- `LINE_DELAY_MS`, 20, extra delay after a downloaded 0x0D.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `baud_rate`  in  1  0 = 9600, 1 = 300; sampled every cycle.
- `dl_active`  in  1  a download is in progress.
- `dl_valid`  in  1  download byte offered.
- `dl_data`  in  8  download byte.
- `dl_ready`  out  1  FIFO not full; a byte is accepted on an edge where `dl_valid & dl_ready`.
- `uart_valid`  in  1  one-cycle strobe, UART byte received; no backpressure.
- `uart_data`  in  8  UART byte.
- `out_valid`  out  1  byte presented to ACIA.
- `out_data`  out  8  presented byte; stable while `out_valid & ~out_ready`.
- `out_ready`  in  1  ACIA accepts; handshake on an edge where `out_valid & out_ready`.
- `uart_drop`  out  1  one-cycle pulse when a UART byte is discarded.
- `busy`  out  1  state ≠ IDLE, FIFO non-empty, or UART hold register full.

## Operation
- Derived constants, integer division: CHAR_CYCLES = CLK_HZ*10/baud, giving 52083 at 9600 and 1666666 at 300. LINE_CYCLES = CLK_HZ/1000*LINE_DELAY_MS, giving 1000000. Counter is 21 bits.
- UART hold register, 1 byte. A strobe loads it if `dl_active`=0 and hold is empty. Otherwise the byte is discarded and `uart_drop` pulses on the next edge.
- FSM states: IDLE, SEND, GAP, LINE.
  - IDLE: if hold is full, move hold into `out_data`, set src=UART, clear hold, go to SEND. Else if FIFO is non-empty, pop into `out_data`, set src=DL, go to SEND. UART has priority.
  - SEND: `out_valid`=1. On handshake: src=UART goes to IDLE; src=DL goes to GAP with cnt=0.
  - GAP: cnt increments each edge. On the edge where cnt = term−1, go to LINE if the sent byte was 0x0D and the macro is enabled; otherwise go to IDLE. term = CHAR_CYCLES for the current `baud_rate`. If cnt ≥ term−1 after a baud change, exit on the next edge.
  - LINE: same counting, terminal LINE_CYCLES, then go to IDLE.
- Falling `dl_active` does not flush the FIFO; remaining bytes drain with pacing.
- FIFO write and pop may occur on the same edge. `dl_ready` derives from the registered count, so a full FIFO never accepts, even on a pop cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `uart_drop`=0, `busy`=0, `dl_ready`=1, FIFO empty, hold empty, state IDLE, cnt=0.
- Reset mid-operation aborts any pending byte immediately; `out_valid` drops asynchronously.
- Download byte accepted at edge E into an idle block: `out_valid` is high from edge E+2.
- UART strobe sampled at edge E while idle: `out_valid` is high from edge E+2.
- After a DL handshake at edge H, the next `out_valid` rises no earlier than edge H+CHAR_CYCLES+1, or H+CHAR_CYCLES+LINE_CYCLES+1 after a 0x0D with the macro enabled.
- UART bytes are not paced. A UART byte arriving during GAP/LINE waits in hold and wins at the next IDLE.
- Capacity with `out_ready`=0 and idle start: FIFO_DEPTH+1 bytes accepted (one is held in the output register).

## Configuration
- `SERIAL_LOAD_LINE_DELAY_EN`
  - Defined: the LINE state is present; a downloaded 0x0D is followed by LINE_CYCLES extra delay.
  - Undefined: the LINE state is removed; 0x0D is paced like any other byte. `LINE_DELAY_MS` is ignored.

## Test plan
- Reset, `baud_rate`=0, `out_ready`=1, `dl_active`=1, download 0x41 then 0x42 → 0x41 `out_valid` at E+2; 0x42 `out_valid` exactly 52084 edges after the 0x41 handshake.
- Download 0x0D, 0x41 at 9600 → 0x41 `out_valid` 1052084 edges after the 0x0D handshake with macro; 52084 without.
- `baud_rate`=1, two download bytes → spacing 1666667 edges. Switch to 0 mid-GAP at cnt=100000 → GAP exits next edge.
- `out_ready`=0, offer 20 download bytes → exactly 17 accepted, `dl_ready` low after the 17th. `out_ready`=1 → bytes emerge in order 1..17.
- `dl_active`=1, UART strobe 0x55 → `uart_drop` one-cycle pulse, no output. `dl_active`=0 during GAP with FIFO holding 0x42, UART strobe 0x55 → 0x55 emitted before 0x42. Second UART strobe while hold is full → `uart_drop` pulse.
- Assert `reset` mid-GAP with 5 bytes queued → `out_valid`=0 and `busy`=0 immediately, `dl_ready`=1. After release, nothing is emitted until new input arrives.

Source files
------------

// File: rtl/serial_load_arbiter.sv
// rtl/serial_load_arbiter.sv - paced download FIFO merged with UART bytes into the ACIA receive stream (option: SERIAL_LOAD_LINE_DELAY_EN)

module serial_load_arbiter #(
    parameter int CLK_HZ        = 50000000,
    parameter int FIFO_DEPTH    = 16,
    parameter int LINE_DELAY_MS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_rate,
    input  logic       dl_active,
    input  logic       dl_valid,
    input  logic [7:0] dl_data,
    output logic       dl_ready,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       uart_drop,
    output logic       busy
);

    localparam int CNT_W = 21;
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Character time in clocks: 10 bit times per byte at the selected baud.
    localparam logic [CNT_W-1:0] CHAR_FAST = CNT_W'(CLK_HZ * 10 / 9600);
    localparam logic [CNT_W-1:0] CHAR_SLOW = CNT_W'(CLK_HZ * 10 / 300);
`ifdef SERIAL_LOAD_LINE_DELAY_EN
    localparam logic [CNT_W-1:0] LINE_TERM = CNT_W'(CLK_HZ / 1000 * LINE_DELAY_MS);
`endif
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef SERIAL_LOAD_LINE_DELAY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_LINE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] term;
    logic             src_uart;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;

    logic             hold_full;
    logic [7:0]       hold_data;
    logic             hold_load, hold_take;

    assign dl_ready  = (count != FIFO_FULL);
    assign push      = dl_valid & dl_ready;
    assign out_valid = (state == S_SEND);
    assign busy      = (state != S_IDLE) | (count != '0) | hold_full;
    assign term      = baud_rate ? CHAR_SLOW : CHAR_FAST;

    // UART bytes are only taken while no download runs and the hold slot is free.
    assign hold_load = uart_valid & ~dl_active & ~hold_full;

    // Next-state logic: UART hold wins over the FIFO; only download bytes are paced.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        hold_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    hold_take = 1'b1;
                    state_nxt = S_SEND;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = src_uart ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                // >= so a baud switch that shortens the terminal exits at once.
                if (cnt >= term - 1'b1) begin
                    cnt_nxt = '0;
`ifdef SERIAL_LOAD_LINE_DELAY_EN
                    state_nxt = (out_data == 8'h0D) ? S_LINE : S_IDLE;
`else
                    state_nxt = S_IDLE;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef SERIAL_LOAD_LINE_DELAY_EN
            S_LINE: begin
                if (cnt >= LINE_TERM - 1'b1) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pacing counter and the output byte register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            out_data <= 8'h00;
            src_uart <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hold_take) begin
                out_data <= hold_data;
                src_uart <= 1'b1;
            end else if (pop) begin
                out_data <= mem[rd_ptr];
                src_uart <= 1'b0;
            end
        end
    end

    // Download FIFO storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dl_data;
        end
    end

    // Download FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // UART hold register and drop pulse for bytes that cannot be held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            uart_drop <= 1'b0;
        end else begin
            uart_drop <= uart_valid & ~hold_load;
            if (hold_load) begin
                hold_full <= 1'b1;
                hold_data <= uart_data;
            end else if (hold_take) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_load_arbiter.sv
// tb/tb_serial_load_arbiter.sv - directed self-checking bench for serial_load_arbiter

module tb_serial_load_arbiter;

    // Scaled clock so character times stay short: 96000*10/9600 = 100, 96000*10/300 = 3200.
    localparam int CLK_HZ        = 96000;
    localparam int FIFO_DEPTH    = 16;
    localparam int LINE_DELAY_MS = 20;
    localparam int CHAR_FAST     = 100;
    localparam int CHAR_SLOW     = 3200;
    localparam int LINE_CYC      = 1920;
`ifdef SERIAL_LOAD_LINE_DELAY_EN
    localparam int CR_SPACING = CHAR_FAST + LINE_CYC + 1;
`else
    localparam int CR_SPACING = CHAR_FAST + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_rate;
    logic       dl_active;
    logic       dl_valid;
    logic [7:0] dl_data;
    logic       dl_ready;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       uart_drop;
    logic       busy;

    serial_load_arbiter #(
        .CLK_HZ       (CLK_HZ),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .LINE_DELAY_MS(LINE_DELAY_MS)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .baud_rate (baud_rate),
        .dl_active (dl_active),
        .dl_valid  (dl_valid),
        .dl_data   (dl_data),
        .dl_ready  (dl_ready),
        .uart_valid(uart_valid),
        .uart_data (uart_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .uart_drop (uart_drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations: rise_edge = edge after which out_valid went high,
    // hs_edge = edge on which the handshake happens, drop_edge = edge that raised uart_drop.
    int         rise_edge[$];
    int         hs_edge[$];
    logic [7:0] hs_data[$];
    int         drop_edge[$];
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_valid) rise_edge.push_back(cyc);
            if (out_valid && out_ready) begin
                hs_data.push_back(out_data);
                hs_edge.push_back(cyc + 1);
            end
            if (uart_drop) drop_edge.push_back(cyc);
        end
        prev_valid = out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rise_edge.delete();
        hs_edge.delete();
        hs_data.delete();
        drop_edge.delete();
    endtask

    task automatic push_dl(input logic [7:0] d);
        dl_valid = 1'b1;
        dl_data  = d;
        step();
        dl_valid = 1'b0;
    endtask

    task automatic uart_strobe(input logic [7:0] d);
        uart_valid = 1'b1;
        uart_data  = d;
        step();
        uart_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 10000 && busy; i++) step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; baud_rate = 1'b0; dl_active = 1'b0; dl_valid = 1'b0; dl_data = 8'h00;
        uart_valid = 1'b0; uart_data = 8'h00; out_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h required 00", out_data); end
        n_cmp++; if (uart_drop !== 1'b0) begin n_bad++; $display("FAIL reset_uart_drop: got %b required 0", uart_drop); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (dl_ready !== 1'b1) begin n_bad++; $display("FAIL reset_dl_ready: got %b required 1", dl_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pacing();
        int e;
        baud_rate = 1'b0; out_ready = 1'b1; dl_active = 1'b1;
        clear_logs();
        push_dl(8'h41);
        e = cyc;
        push_dl(8'h42);
        for (int i = 0; i < 1000 && hs_data.size() < 2; i++) step();
        n_cmp++;
        if (hs_data.size() < 2) begin
            n_bad++; $display("FAIL pacing_timeout: got %0d bytes required 2", hs_data.size());
        end else begin
            n_cmp++; if (rise_edge[0] !== e + 1) begin n_bad++; $display("FAIL pacing_first_latency: rise edge %0d required %0d", rise_edge[0], e + 1); end
            n_cmp++; if (hs_data[0] !== 8'h41) begin n_bad++; $display("FAIL pacing_byte0: got %h required 41", hs_data[0]); end
            n_cmp++; if (hs_data[1] !== 8'h42) begin n_bad++; $display("FAIL pacing_byte1: got %h required 42", hs_data[1]); end
            n_cmp++; if (rise_edge[1] - hs_edge[0] !== CHAR_FAST + 1) begin n_bad++; $display("FAIL pacing_spacing: got %0d required %0d", rise_edge[1] - hs_edge[0], CHAR_FAST + 1); end
        end
        wait_idle("pacing");
    endtask

    task automatic test_line_delay();
        clear_logs();
        push_dl(8'h0D);
        push_dl(8'h41);
        for (int i = 0; i < 5000 && hs_data.size() < 2; i++) step();
        n_cmp++;
        if (hs_data.size() < 2) begin
            n_bad++; $display("FAIL cr_timeout: got %0d bytes required 2", hs_data.size());
        end else begin
            n_cmp++; if (hs_data[1] !== 8'h41) begin n_bad++; $display("FAIL cr_byte1: got %h required 41", hs_data[1]); end
            n_cmp++; if (rise_edge[1] - hs_edge[0] !== CR_SPACING) begin n_bad++; $display("FAIL cr_spacing: got %0d required %0d", rise_edge[1] - hs_edge[0], CR_SPACING); end
        end
        wait_idle("cr");
    endtask

    task automatic test_baud_change();
        int h2;
        baud_rate = 1'b1;
        clear_logs();
        push_dl(8'h01);
        push_dl(8'h02);
        push_dl(8'h03);
        for (int i = 0; i < 5000 && hs_data.size() < 2; i++) step();
        n_cmp++;
        if (hs_data.size() < 2) begin
            n_bad++; $display("FAIL baud_timeout: got %0d bytes required 2", hs_data.size());
        end else begin
            n_cmp++; if (rise_edge[1] - hs_edge[0] !== CHAR_SLOW + 1) begin n_bad++; $display("FAIL baud_slow_spacing: got %0d required %0d", rise_edge[1] - hs_edge[0], CHAR_SLOW + 1); end
            // Switch to 9600 once the GAP counter holds 501, well past the fast terminal.
            h2 = hs_edge[1];
            while (cyc < h2 + 501) step();
            baud_rate = 1'b0;
            for (int i = 0; i < 1000 && hs_data.size() < 3; i++) step();
            n_cmp++;
            if (hs_data.size() < 3) begin
                n_bad++; $display("FAIL baud_switch_timeout: got %0d bytes required 3", hs_data.size());
            end else begin
                n_cmp++; if (rise_edge[2] - h2 !== 503) begin n_bad++; $display("FAIL baud_switch_exit: got %0d required 503", rise_edge[2] - h2); end
                n_cmp++; if (hs_data[2] !== 8'h03) begin n_bad++; $display("FAIL baud_switch_byte: got %h required 03", hs_data[2]); end
            end
        end
        wait_idle("baud");
    endtask

    task automatic test_capacity();
        int acc;
        int nxt;
        out_ready = 1'b0; dl_active = 1'b1; baud_rate = 1'b0;
        clear_logs();
        acc = 0;
        nxt = 1;
        for (int i = 0; i < 40; i++) begin
            dl_valid = (nxt <= 20);
            dl_data  = 8'(nxt);
            @(negedge clk);
            if (dl_valid && dl_ready) begin
                acc++;
                nxt++;
            end
            step();
        end
        dl_valid = 1'b0;
        n_cmp++; if (acc !== FIFO_DEPTH + 1) begin n_bad++; $display("FAIL cap_accepted: got %0d required %0d", acc, FIFO_DEPTH + 1); end
        n_cmp++; if (dl_ready !== 1'b0) begin n_bad++; $display("FAIL cap_dl_ready: got %b required 0", dl_ready); end
        n_cmp++; if (out_data !== 8'h01) begin n_bad++; $display("FAIL cap_held_byte: got %h required 01", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4000 && hs_data.size() < 17; i++) step();
        n_cmp++;
        if (hs_data.size() !== 17) begin
            n_bad++; $display("FAIL cap_drain_count: got %0d required 17", hs_data.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                n_cmp++;
                if (hs_data[k] !== 8'(k + 1)) begin n_bad++; $display("FAIL cap_order_%0d: got %h required %h", k, hs_data[k], 8'(k + 1)); end
            end
        end
        wait_idle("cap");
    endtask

    task automatic test_uart();
        int e;
        // UART during a download is dropped.
        dl_active = 1'b1; out_ready = 1'b1;
        clear_logs();
        uart_strobe(8'h55);
        e = cyc;
        repeat (5) step();
        n_cmp++; if (drop_edge.size() !== 1) begin n_bad++; $display("FAIL uart_drop_pulse_len: got %0d cycles required 1", drop_edge.size()); end
        else begin n_cmp++; if (drop_edge[0] !== e) begin n_bad++; $display("FAIL uart_drop_edge: got %0d required %0d", drop_edge[0], e); end end
        n_cmp++; if (rise_edge.size() !== 0) begin n_bad++; $display("FAIL uart_drop_no_output: got %0d outputs required 0", rise_edge.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL uart_drop_busy: got %b required 0", busy); end

        // UART arriving during GAP jumps the queued download byte; a second strobe is dropped.
        clear_logs();
        push_dl(8'h41);
        push_dl(8'h42);
        for (int i = 0; i < 100 && hs_data.size() < 1; i++) step();
        dl_active = 1'b0;
        uart_strobe(8'h55);
        uart_strobe(8'h66);
        for (int i = 0; i < 1000 && hs_data.size() < 3; i++) step();
        n_cmp++;
        if (hs_data.size() < 3) begin
            n_bad++; $display("FAIL uart_prio_timeout: got %0d bytes required 3", hs_data.size());
        end else begin
            n_cmp++; if (hs_data[0] !== 8'h41) begin n_bad++; $display("FAIL uart_prio_b0: got %h required 41", hs_data[0]); end
            n_cmp++; if (hs_data[1] !== 8'h55) begin n_bad++; $display("FAIL uart_prio_b1: got %h required 55", hs_data[1]); end
            n_cmp++; if (hs_data[2] !== 8'h42) begin n_bad++; $display("FAIL uart_prio_b2: got %h required 42", hs_data[2]); end
        end
        n_cmp++; if (drop_edge.size() !== 1) begin n_bad++; $display("FAIL uart_hold_full_drop: got %0d cycles required 1", drop_edge.size()); end
        wait_idle("uart_prio");

        // Idle UART latency.
        clear_logs();
        uart_strobe(8'h77);
        e = cyc;
        for (int i = 0; i < 100 && hs_data.size() < 1; i++) step();
        n_cmp++;
        if (hs_data.size() < 1) begin
            n_bad++; $display("FAIL uart_lat_timeout: got %0d bytes required 1", hs_data.size());
        end else begin
            n_cmp++; if (rise_edge[0] !== e + 1) begin n_bad++; $display("FAIL uart_latency: rise edge %0d required %0d", rise_edge[0], e + 1); end
            n_cmp++; if (hs_data[0] !== 8'h77) begin n_bad++; $display("FAIL uart_lat_byte: got %h required 77", hs_data[0]); end
        end
        wait_idle("uart_lat");
    endtask

    task automatic test_reset_mid();
        dl_active = 1'b1; out_ready = 1'b1; baud_rate = 1'b0;
        clear_logs();
        for (int k = 0; k < 6; k++) push_dl(8'(8'h11 + k));
        for (int i = 0; i < 100 && hs_data.size() < 1; i++) step();
        repeat (10) step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b required 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        n_cmp++; if (dl_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_dl_ready: got %b required 1", dl_ready); end
        step();
        rst = 1'b0;
        dl_active = 1'b0;
        clear_logs();
        repeat (300) step();
        n_cmp++; if (rise_edge.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_output: got %0d outputs required 0", rise_edge.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after: got %b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_pacing();
        test_line_delay();
        test_baud_change();
        test_capacity();
        test_uart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
